mem_req_arbiter: RTL and testbench

//  Arbitrates the single byte-serial RAM engine between ICache fetches and LSB loads/stores.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_starve_ctr.sv | 39 +++
 rtl/mem_req_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the ICache/LSB memory request arbiter.
// Holds the FSM state encoding, LSB opcode codes and the IO-space decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BUSY  = 2'd1,
    LSB_BUSY = 2'd2,
    DRAIN    = 2'd3
  } arb_state_e;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  // IO space is the top quarter of each 256 KiB window, selected by address bits [17:16].
  function automatic logic is_io_addr(input logic [1:0] addr_17_16);
    return addr_17_16 == 2'b11;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive LSB grants taken while a fetch was waiting.
// sat tells the arbiter that the fetch side must win the next grant.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the byte-serial RAM engine between ICache fetches and LSB accesses.
// Define MEM_ARB_STATS_EN to add grant / IO-stall statistics counters.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int OP_W         = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              lsb_req,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [OP_W-1:0]   lsb_op,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_gnt,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [OP_W-1:0]   eng_op,
  output logic [31:0]       eng_wdata,
  input  logic              eng_done,
  input  logic [31:0]       eng_rdata,
  input  logic              io_full
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_ic_gnt,
  output logic [31:0]       stat_lsb_gnt,
  output logic [31:0]       stat_io_stall
`endif
);

  arb_state_e state_q, state_d;

  logic              ic_gnt_q, ic_gnt_d;
  logic              lsb_gnt_q, lsb_gnt_d;
  logic              eng_start_q, eng_start_d;
  logic              ic_done_q, ic_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
  logic [OP_W-1:0]   eng_op_q, eng_op_d;
  logic [31:0]       eng_wdata_q, eng_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic is_idle, lsb_ok, ic_ok, starve_sat;
  logic ic_win, lsb_win, ic_done_evt, lsb_done_evt;
  logic starve_inc, starve_clr;

  // Grant and completion decisions; all of them are qualified by rdy.
  always_comb begin
    is_idle      = (state_q == IDLE);
    lsb_ok       = lsb_req & ~(io_full & is_io_addr(lsb_addr[17:16]));
    ic_ok        = ic_req & ~flush;
    ic_win       = rdy & is_idle & ic_ok & (starve_sat | ~lsb_ok);
    lsb_win      = rdy & is_idle & ~ic_win & lsb_ok;
    ic_done_evt  = rdy & eng_done & (state_q == IC_BUSY) & ~flush;
    lsb_done_evt = rdy & eng_done & (state_q == LSB_BUSY);
    starve_inc   = lsb_win & ic_req;
    starve_clr   = ic_win | (rdy & is_idle & ~ic_req);
  end

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush coinciding with eng_done still lands in IDLE; the result is simply not reported.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (ic_win) begin
            state_d = IC_BUSY;
          end else if (lsb_win) begin
            state_d = LSB_BUSY;
          end
        end
        IC_BUSY: begin
          if (eng_done) begin
            state_d = IDLE;
          end else if (flush) begin
            state_d = DRAIN;
          end
        end
        LSB_BUSY: begin
          if (eng_done) state_d = IDLE;
        end
        DRAIN: begin
          if (eng_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pulses and latches hold while rdy=0 so a pending pulse reappears once rdy returns.
  always_comb begin
    ic_gnt_d    = ic_gnt_q;
    lsb_gnt_d   = lsb_gnt_q;
    eng_start_d = eng_start_q;
    ic_done_d   = ic_done_q;
    lsb_done_d  = lsb_done_q;
    eng_addr_d  = eng_addr_q;
    eng_op_d    = eng_op_q;
    eng_wdata_d = eng_wdata_q;
    rdata_d     = rdata_q;
    if (rdy) begin
      ic_gnt_d    = ic_win;
      lsb_gnt_d   = lsb_win;
      eng_start_d = ic_win | lsb_win;
      ic_done_d   = ic_done_evt;
      lsb_done_d  = lsb_done_evt;
    end
    if (ic_win) begin
      eng_addr_d  = ic_addr;
      eng_op_d    = OP_W'(OP_LW);
      eng_wdata_d = '0;
    end else if (lsb_win) begin
      eng_addr_d  = lsb_addr;
      eng_op_d    = lsb_op;
      eng_wdata_d = lsb_wdata;
    end
    if (ic_done_evt | lsb_done_evt) begin
      rdata_d = eng_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_gnt_q    <= 1'b0;
      lsb_gnt_q   <= 1'b0;
      eng_start_q <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      eng_addr_q  <= '0;
      eng_op_q    <= '0;
      eng_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      ic_gnt_q    <= ic_gnt_d;
      lsb_gnt_q   <= lsb_gnt_d;
      eng_start_q <= eng_start_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      eng_addr_q  <= eng_addr_d;
      eng_op_q    <= eng_op_d;
      eng_wdata_q <= eng_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ic_gnt    = ic_gnt_q & rdy;
  assign lsb_gnt   = lsb_gnt_q & rdy;
  assign eng_start = eng_start_q & rdy;
  assign ic_done   = ic_done_q & rdy;
  assign lsb_done  = lsb_done_q & rdy;
  assign eng_addr  = eng_addr_q;
  assign eng_op    = eng_op_q;
  assign eng_wdata = eng_wdata_q;
  assign ic_data   = rdata_q;
  assign lsb_rdata = rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ic_gnt_q, stat_ic_gnt_d;
  logic [31:0] stat_lsb_gnt_q, stat_lsb_gnt_d;
  logic [31:0] stat_io_stall_q, stat_io_stall_d;

  always_comb begin
    stat_ic_gnt_d   = stat_ic_gnt_q + {31'd0, ic_win};
    stat_lsb_gnt_d  = stat_lsb_gnt_q + {31'd0, lsb_win};
    stat_io_stall_d = stat_io_stall_q + {31'd0, rdy & is_idle & lsb_req & ~lsb_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ic_gnt_q   <= '0;
      stat_lsb_gnt_q  <= '0;
      stat_io_stall_q <= '0;
    end else begin
      stat_ic_gnt_q   <= stat_ic_gnt_d;
      stat_lsb_gnt_q  <= stat_lsb_gnt_d;
      stat_io_stall_q <= stat_io_stall_d;
    end
  end

  assign stat_ic_gnt   = stat_ic_gnt_q;
  assign stat_lsb_gnt  = stat_lsb_gnt_q;
  assign stat_io_stall = stat_io_stall_q;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; the bench plays the RAM engine.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt, ic_done;
  logic [31:0] ic_data;
  logic        lsb_req;
  logic [31:0] lsb_addr;
  logic [5:0]  lsb_op;
  logic [31:0] lsb_wdata;
  logic        lsb_gnt, lsb_done;
  logic [31:0] lsb_rdata;
  logic        eng_start;
  logic [31:0] eng_addr;
  logic [5:0]  eng_op;
  logic [31:0] eng_wdata;
  logic        eng_done;
  logic [31:0] eng_rdata;
  logic        io_full;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ic_gnt, stat_lsb_gnt, stat_io_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W       (32),
    .OP_W         (6),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .flush     (flush),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_gnt    (ic_gnt),
    .ic_done   (ic_done),
    .ic_data   (ic_data),
    .lsb_req   (lsb_req),
    .lsb_addr  (lsb_addr),
    .lsb_op    (lsb_op),
    .lsb_wdata (lsb_wdata),
    .lsb_gnt   (lsb_gnt),
    .lsb_done  (lsb_done),
    .lsb_rdata (lsb_rdata),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_op    (eng_op),
    .eng_wdata (eng_wdata),
    .eng_done  (eng_done),
    .eng_rdata (eng_rdata),
    .io_full   (io_full)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ic_gnt   (stat_ic_gnt),
    .stat_lsb_gnt  (stat_lsb_gnt),
    .stat_io_stall (stat_io_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle engine completion; returns in the cycle where done/data are visible.
  task automatic eng_finish(input logic [31:0] data);
    eng_done  = 1'b1;
    eng_rdata = data;
    tick();
    eng_done  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_addr = '0; lsb_op = '0; lsb_wdata = '0;
    eng_done = 1'b0; eng_rdata = '0;
    #3;
    n_chk++; if ({ic_gnt, ic_done, lsb_gnt, lsb_done, eng_start} !== 5'b0) $display("FAIL rst_pulses: got %b want 00000", {ic_gnt, ic_done, lsb_gnt, lsb_done, eng_start}); else n_pass++;
    n_chk++; if ({eng_addr, eng_wdata, ic_data, lsb_rdata} !== 128'd0) $display("FAIL rst_data: got %h want 0", {eng_addr, eng_wdata, ic_data, lsb_rdata}); else n_pass++;
    n_chk++; if (eng_op !== 6'd0) $display("FAIL rst_op: got %h want 0", eng_op); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if ({ic_gnt, lsb_gnt, eng_start} !== 3'b0) $display("FAIL rst_idle: got %b want 000", {ic_gnt, lsb_gnt, eng_start}); else n_pass++;
  endtask

  task automatic test_lsb_basic();
    lsb_req = 1'b1; lsb_addr = 32'h100; lsb_op = OP_LW; lsb_wdata = '0;
    tick();
    n_chk++; if (lsb_gnt !== 1'b1) $display("FAIL t1_gnt: got %b want 1", lsb_gnt); else n_pass++;
    n_chk++; if (eng_start !== 1'b1) $display("FAIL t1_start: got %b want 1", eng_start); else n_pass++;
    n_chk++; if (eng_addr !== 32'h100) $display("FAIL t1_addr: got %h want 00000100", eng_addr); else n_pass++;
    n_chk++; if (eng_op !== OP_LW) $display("FAIL t1_op: got %h want %h", eng_op, OP_LW); else n_pass++;
    n_chk++; if (ic_gnt !== 1'b0) $display("FAIL t1_icgnt: got %b want 0", ic_gnt); else n_pass++;
    lsb_req = 1'b0;
    tick();
    n_chk++; if ({lsb_gnt, eng_start} !== 2'b00) $display("FAIL t1_pulse_len: got %b want 00", {lsb_gnt, eng_start}); else n_pass++;
    eng_finish(32'hDEAD_BEEF);
    n_chk++; if (lsb_done !== 1'b1) $display("FAIL t1_done: got %b want 1", lsb_done); else n_pass++;
    n_chk++; if (lsb_rdata !== 32'hDEAD_BEEF) $display("FAIL t1_rdata: got %h want deadbeef", lsb_rdata); else n_pass++;
    n_chk++; if (ic_done !== 1'b0) $display("FAIL t1_icdone: got %b want 0", ic_done); else n_pass++;
    // Back-to-back: a request in the completion cycle starts the engine in the next one.
    lsb_req = 1'b1; lsb_addr = 32'h104; lsb_op = OP_SW; lsb_wdata = 32'h1234_5678;
    tick();
    n_chk++; if ({lsb_done, eng_start} !== 2'b01) $display("FAIL t1_b2b_start: got %b want 01", {lsb_done, eng_start}); else n_pass++;
    n_chk++; if ({eng_addr, eng_wdata} !== {32'h104, 32'h1234_5678}) $display("FAIL t1_b2b_latch: got %h want 0000010412345678", {eng_addr, eng_wdata}); else n_pass++;
    lsb_req = 1'b0;
    tick();
    eng_finish(32'h0);
    n_chk++; if (lsb_done !== 1'b1) $display("FAIL t1_b2b_done: got %b want 1", lsb_done); else n_pass++;
  endtask

  task automatic test_starvation();
    string exp_seq = "LLLLILLLLI";
    ic_req = 1'b1; ic_addr = 32'h2000;
    lsb_req = 1'b1; lsb_addr = 32'h200; lsb_op = OP_LW;
    for (int g = 0; g < 10; g++) begin
      byte got;
      logic [31:0] d;
      got = "-";
      d = 32'hA000_0000 + g;
      for (int c = 0; c < 20 && got == "-"; c++) begin
        tick();
        if (ic_gnt && lsb_gnt) got = "B";
        else if (ic_gnt) got = "I";
        else if (lsb_gnt) got = "L";
      end
      n_chk++; if (got != exp_seq[g]) $display("FAIL t2_grant%0d: got %c want %c", g, got, exp_seq[g]); else n_pass++;
      tick();
      eng_finish(d);
      if (exp_seq[g] == "I") begin
        n_chk++; if ({ic_done, lsb_done, ic_data} !== {2'b10, d}) $display("FAIL t2_icdone%0d: got %h want %h", g, {ic_done, lsb_done, ic_data}, {2'b10, d}); else n_pass++;
      end else begin
        n_chk++; if ({ic_done, lsb_done, lsb_rdata} !== {2'b01, d}) $display("FAIL t2_lsbdone%0d: got %h want %h", g, {ic_done, lsb_done, lsb_rdata}, {2'b01, d}); else n_pass++;
      end
    end
    ic_req = 1'b0; lsb_req = 1'b0;
    tick();
  endtask

  task automatic test_io_defer();
    lsb_req = 1'b1; lsb_addr = 32'h0003_0000; lsb_op = OP_SB; lsb_wdata = 32'h55;
    io_full = 1'b1; ic_req = 1'b1; ic_addr = 32'h3000;
    tick();
    n_chk++; if ({ic_gnt, lsb_gnt} !== 2'b10) $display("FAIL t3_ic_first: got %b want 10", {ic_gnt, lsb_gnt}); else n_pass++;
    n_chk++; if ({eng_addr, eng_op} !== {32'h3000, OP_LW}) $display("FAIL t3_ic_latch: got %h want %h", {eng_addr, eng_op}, {32'h3000, OP_LW}); else n_pass++;
    ic_req = 1'b0;
    tick();
    eng_finish(32'h1111_2222);
    n_chk++; if ({ic_done, ic_data} !== {1'b1, 32'h1111_2222}) $display("FAIL t3_icdone: got %h want 111112222", {ic_done, ic_data}); else n_pass++;
    tick();
    n_chk++; if (lsb_gnt !== 1'b0) $display("FAIL t3_io_held: got %b want 0", lsb_gnt); else n_pass++;
    io_full = 1'b0;
    tick();
    n_chk++; if (lsb_gnt !== 1'b1) $display("FAIL t3_io_gnt: got %b want 1", lsb_gnt); else n_pass++;
    n_chk++; if ({eng_addr, eng_op, eng_wdata} !== {32'h0003_0000, OP_SB, 32'h55}) $display("FAIL t3_io_latch: got %h want %h", {eng_addr, eng_op, eng_wdata}, {32'h0003_0000, OP_SB, 32'h55}); else n_pass++;
    lsb_req = 1'b0;
    tick();
    eng_finish(32'h0);
    n_chk++; if (lsb_done !== 1'b1) $display("FAIL t3_io_done: got %b want 1", lsb_done); else n_pass++;
  endtask

  task automatic test_flush();
    ic_req = 1'b1; ic_addr = 32'h4000;
    tick();
    n_chk++; if (ic_gnt !== 1'b1) $display("FAIL t4_icgnt: got %b want 1", ic_gnt); else n_pass++;
    ic_req = 1'b0;
    lsb_req = 1'b1; lsb_addr = 32'h500; lsb_op = OP_LW;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++; if ({ic_done, lsb_gnt, eng_start} !== 3'b000) $display("FAIL t4_drain%0d: got %b want 000", k, {ic_done, lsb_gnt, eng_start}); else n_pass++;
    end
    eng_finish(32'h7777_7777);
    n_chk++; if ({ic_done, lsb_gnt} !== 2'b00) $display("FAIL t4_discard: got %b want 00", {ic_done, lsb_gnt}); else n_pass++;
    tick();
    n_chk++; if ({lsb_gnt, ic_done} !== 2'b10) $display("FAIL t4_lsb_after: got %b want 10", {lsb_gnt, ic_done}); else n_pass++;
    lsb_req = 1'b0;
    tick();
    eng_finish(32'h8888_0000);
    n_chk++; if ({lsb_done, lsb_rdata} !== {1'b1, 32'h8888_0000}) $display("FAIL t4_lsb_done: got %h want 188880000", {lsb_done, lsb_rdata}); else n_pass++;
    // flush and eng_done in the same IC_BUSY cycle: discard and return straight to IDLE.
    ic_req = 1'b1; ic_addr = 32'h4100;
    tick();
    ic_req = 1'b0;
    flush = 1'b1;
    eng_finish(32'h9999_9999);
    flush = 1'b0;
    n_chk++; if (ic_done !== 1'b0) $display("FAIL t4_same_cycle: got %b want 0", ic_done); else n_pass++;
    ic_req = 1'b1; ic_addr = 32'h4200;
    tick();
    n_chk++; if ({ic_gnt, eng_addr} !== {1'b1, 32'h4200}) $display("FAIL t4_regrant: got %h want 100004200", {ic_gnt, eng_addr}); else n_pass++;
    ic_req = 1'b0;
    tick();
    eng_finish(32'hABCD_0123);
    n_chk++; if ({ic_done, ic_data} !== {1'b1, 32'hABCD_0123}) $display("FAIL t4_regrant_done: got %h want 1abcd0123", {ic_done, ic_data}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    ic_req = 1'b1; ic_addr = 32'h6000;
    lsb_req = 1'b1; lsb_addr = 32'h900; lsb_op = OP_LW;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++; if ({ic_gnt, lsb_gnt} !== 2'b01) $display("FAIL t5_build%0d: got %b want 01", k, {ic_gnt, lsb_gnt}); else n_pass++;
      if (k < 3) begin
        tick();
        eng_finish(32'h5500 + k);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({ic_gnt, lsb_gnt, eng_start, ic_done, lsb_done} !== 5'b0) $display("FAIL t5_rst_pulses: got %b want 00000", {ic_gnt, lsb_gnt, eng_start, ic_done, lsb_done}); else n_pass++;
    n_chk++; if ({eng_addr, lsb_rdata} !== 64'd0) $display("FAIL t5_rst_data: got %h want 0", {eng_addr, lsb_rdata}); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    // A surviving saturated counter would hand this grant to IC instead.
    n_chk++; if ({ic_gnt, lsb_gnt} !== 2'b01) $display("FAIL t5_post_rst: got %b want 01", {ic_gnt, lsb_gnt}); else n_pass++;
    ic_req = 1'b0; lsb_req = 1'b0;
    tick();
    eng_finish(32'h0BAD_F00D);
    n_chk++; if ({lsb_done, lsb_rdata} !== {1'b1, 32'h0BAD_F00D}) $display("FAIL t5_post_done: got %h want 10badf00d", {lsb_done, lsb_rdata}); else n_pass++;
  endtask

  task automatic test_rdy_hold();
    lsb_req = 1'b1; lsb_addr = 32'h600; lsb_op = OP_LW;
    tick();
    n_chk++; if (lsb_gnt !== 1'b1) $display("FAIL t6_gnt: got %b want 1", lsb_gnt); else n_pass++;
    lsb_req = 1'b0;
    tick();
    eng_finish(32'hCAFE_F00D);
    rdy = 1'b0;
    lsb_req = 1'b1; lsb_addr = 32'h700;
    #1;
    n_chk++; if (lsb_done !== 1'b0) $display("FAIL t6_gated0: got %b want 0", lsb_done); else n_pass++;
    tick();
    n_chk++; if ({lsb_done, lsb_gnt, eng_start} !== 3'b000) $display("FAIL t6_frozen1: got %b want 000", {lsb_done, lsb_gnt, eng_start}); else n_pass++;
    tick();
    n_chk++; if ({lsb_done, lsb_gnt, eng_start} !== 3'b000) $display("FAIL t6_frozen2: got %b want 000", {lsb_done, lsb_gnt, eng_start}); else n_pass++;
    tick();
    rdy = 1'b1;
    #1;
    n_chk++; if ({lsb_done, lsb_gnt} !== 2'b10) $display("FAIL t6_released: got %b want 10", {lsb_done, lsb_gnt}); else n_pass++;
    n_chk++; if (lsb_rdata !== 32'hCAFE_F00D) $display("FAIL t6_data: got %h want cafef00d", lsb_rdata); else n_pass++;
    tick();
    n_chk++; if ({lsb_done, lsb_gnt, eng_addr} !== {2'b01, 32'h700}) $display("FAIL t6_next_gnt: got %h want 100000700", {lsb_done, lsb_gnt, eng_addr}); else n_pass++;
    lsb_req = 1'b0;
    tick();
    eng_finish(32'h1);
    n_chk++; if ({lsb_done, lsb_rdata} !== {1'b1, 32'h1}) $display("FAIL t6_next_done: got %h want 100000001", {lsb_done, lsb_rdata}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_starvation();
    test_io_defer();
    test_flush();
    test_reset_mid();
    test_rdy_hold();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
